branch_table_loader: RTL

- Sequences writes into the per-thread Branch Origin, Destination and Condition memories of the branching unit.
- Arbitrates between two sources:
  - ALU memory-mapped writes, which always have priority.
  - A buffered configuration port (boot loader / debug), which commits a whole branch entry atomically.
- Sits between the ALU write path and the branch memories, replacing the direct ALU_wren_* hookup.

---
 rtl/branch_table_loader.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/branch_table_loader.sv
// -----------------------------------------------------------------------------
// branch_table_loader
//
// Write sequencer for the per-thread Branch Origin (BO), Destination (BD) and
// Condition (BC) memories. It merges two write sources onto one registered
// memory write port:
//   - ALU memory-mapped writes, which always win arbitration;
//   - a small FIFO of configuration entries (boot loader / debug). Each entry
//     writes all of its enabled memories in the same cycle, so a branch check
//     never sees a partially updated entry.
//
// Ports:
//   clock, reset_n          system clock, asynchronous active-low reset
//   cfg_valid / cfg_ready   config entry handshake (ready = FIFO not full)
//   cfg_thread, cfg_mask    target thread and write enables {BC,BD,BO}
//   cfg_origin/_destination/_condition   config entry payload
//   cfg_flush               synchronous discard of all buffered entries
//   ALU_wren_BO/BD/BC       ALU write requests
//   ALU_write_addr, ALU_write_data_BO/BD/BC   ALU write address and data
//   read_thread             thread currently read by the branch check
//   wren_BO/BD/BC           registered memory write enables
//   write_addr              registered memory write address
//   write_data_BO/BD/BC     registered memory write data
//   pending                 FIFO occupancy
//   stall_count             saturating count of cycles the FIFO head was blocked
// -----------------------------------------------------------------------------
module branch_table_loader #(
    parameter int D_OPERAND_WIDTH        = 10,
    parameter int THREAD_ADDR_WIDTH      = 3,
    parameter int ORIGIN_WORD_WIDTH      = 10,
    parameter int DESTINATION_WORD_WIDTH = 10,
    parameter int CONDITION_WORD_WIDTH   = 3,
    parameter int FIFO_DEPTH             = 4,
    parameter int FIFO_ADDR_WIDTH        = 2,
    parameter int STALL_COUNT_WIDTH      = 8
) (
    input  logic                              clock,
    input  logic                              reset_n,

    input  logic                              cfg_valid,
    output logic                              cfg_ready,
    input  logic [THREAD_ADDR_WIDTH-1:0]      cfg_thread,
    input  logic [2:0]                        cfg_mask,
    input  logic [ORIGIN_WORD_WIDTH-1:0]      cfg_origin,
    input  logic [DESTINATION_WORD_WIDTH-1:0] cfg_destination,
    input  logic [CONDITION_WORD_WIDTH-1:0]   cfg_condition,
    input  logic                              cfg_flush,

    input  logic                              ALU_wren_BO,
    input  logic                              ALU_wren_BD,
    input  logic                              ALU_wren_BC,
    input  logic [D_OPERAND_WIDTH-1:0]        ALU_write_addr,
    input  logic [ORIGIN_WORD_WIDTH-1:0]      ALU_write_data_BO,
    input  logic [DESTINATION_WORD_WIDTH-1:0] ALU_write_data_BD,
    input  logic [CONDITION_WORD_WIDTH-1:0]   ALU_write_data_BC,

    input  logic [THREAD_ADDR_WIDTH-1:0]      read_thread,

    output logic                              wren_BO,
    output logic                              wren_BD,
    output logic                              wren_BC,
    output logic [D_OPERAND_WIDTH-1:0]        write_addr,
    output logic [ORIGIN_WORD_WIDTH-1:0]      write_data_BO,
    output logic [DESTINATION_WORD_WIDTH-1:0] write_data_BD,
    output logic [CONDITION_WORD_WIDTH-1:0]   write_data_BC,

    output logic [FIFO_ADDR_WIDTH:0]          pending,
    output logic [STALL_COUNT_WIDTH-1:0]      stall_count
);

    localparam logic [FIFO_ADDR_WIDTH:0] FULL_COUNT = (FIFO_ADDR_WIDTH+1)'(FIFO_DEPTH);

    // FIFO storage: payload only, no reset needed since occupancy guards reads
    logic [THREAD_ADDR_WIDTH-1:0]      thr_mem  [FIFO_DEPTH];
    logic [2:0]                        mask_mem [FIFO_DEPTH];
    logic [ORIGIN_WORD_WIDTH-1:0]      org_mem  [FIFO_DEPTH];
    logic [DESTINATION_WORD_WIDTH-1:0] dst_mem  [FIFO_DEPTH];
    logic [CONDITION_WORD_WIDTH-1:0]   cnd_mem  [FIFO_DEPTH];

    logic [FIFO_ADDR_WIDTH-1:0]        rd_ptr_q, rd_ptr_d;
    logic [FIFO_ADDR_WIDTH-1:0]        wr_ptr_q, wr_ptr_d;
    logic [FIFO_ADDR_WIDTH:0]          count_q, count_d;
    logic [STALL_COUNT_WIDTH-1:0]      stall_q, stall_d;

    logic [2:0]                        wren_q, wren_d;
    logic [D_OPERAND_WIDTH-1:0]        addr_q, addr_d;
    logic [ORIGIN_WORD_WIDTH-1:0]      dbo_q, dbo_d;
    logic [DESTINATION_WORD_WIDTH-1:0] dbd_q, dbd_d;
    logic [CONDITION_WORD_WIDTH-1:0]   dbc_q, dbc_d;

    logic                              alu_hit;
    logic                              non_empty;
    logic                              head_ok;
    logic                              enq;
    logic                              deq;
    logic [THREAD_ADDR_WIDTH-1:0]      head_thr;

    // Ready depends only on registered occupancy, so a same-cycle dequeue
    // from a full FIFO does not open the port until the next cycle.
    assign cfg_ready = (count_q != FULL_COUNT);

    assign alu_hit   = ALU_wren_BO | ALU_wren_BD | ALU_wren_BC;
    assign non_empty = (count_q != '0);
    assign head_thr  = thr_mem[rd_ptr_q];

    // The head is held back while its thread is being read so the branch
    // check never observes a half-written entry.
    assign head_ok   = non_empty & ~alu_hit & (head_thr != read_thread);

    // Flush wins over both enqueue and dequeue.
    assign enq = cfg_valid & cfg_ready & ~cfg_flush;
    assign deq = head_ok & ~cfg_flush;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        stall_d  = stall_q;
        wren_d   = 3'b000;
        addr_d   = addr_q;
        dbo_d    = dbo_q;
        dbd_d    = dbd_q;
        dbc_d    = dbc_q;

        if (alu_hit) begin
            wren_d = {ALU_wren_BC, ALU_wren_BD, ALU_wren_BO};
            addr_d = ALU_write_addr;
            dbo_d  = ALU_write_data_BO;
            dbd_d  = ALU_write_data_BD;
            dbc_d  = ALU_write_data_BC;
        end else if (deq) begin
            // A zero mask still dequeues; it simply produces no write.
            wren_d = mask_mem[rd_ptr_q];
            addr_d = {{(D_OPERAND_WIDTH-THREAD_ADDR_WIDTH){1'b0}}, head_thr};
            dbo_d  = org_mem[rd_ptr_q];
            dbd_d  = dst_mem[rd_ptr_q];
            dbc_d  = cnd_mem[rd_ptr_q];
        end

        if (non_empty && !head_ok && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end

        if (cfg_flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) wr_ptr_d = wr_ptr_q + 1'b1;
            if (deq) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({enq, deq})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            stall_q  <= '0;
            wren_q   <= '0;
            addr_q   <= '0;
            dbo_q    <= '0;
            dbd_q    <= '0;
            dbc_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            stall_q  <= stall_d;
            wren_q   <= wren_d;
            addr_q   <= addr_d;
            dbo_q    <= dbo_d;
            dbd_q    <= dbd_d;
            dbc_q    <= dbc_d;
        end
    end

    always_ff @(posedge clock) begin
        if (enq) begin
            thr_mem[wr_ptr_q]  <= cfg_thread;
            mask_mem[wr_ptr_q] <= cfg_mask;
            org_mem[wr_ptr_q]  <= cfg_origin;
            dst_mem[wr_ptr_q]  <= cfg_destination;
            cnd_mem[wr_ptr_q]  <= cfg_condition;
        end
    end

    assign wren_BO       = wren_q[0];
    assign wren_BD       = wren_q[1];
    assign wren_BC       = wren_q[2];
    assign write_addr    = addr_q;
    assign write_data_BO = dbo_q;
    assign write_data_BD = dbd_q;
    assign write_data_BC = dbc_q;
    assign pending       = count_q;
    assign stall_count   = stall_q;

endmodule
